// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int SPI_WORD_DEFAULT = 8;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_reg <= '0;
      prev_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync = chain_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with a one-word tx buffer and pulsed rx strobe.
// Optional sticky underrun flag when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int N           = SPI_WORD_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         ss_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic         underrun,
  input  logic         underrun_clr
`endif
);
  localparam int CW = $clog2(N);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level_unused, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .din(ss_n),
    .sync(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t         state_reg, state_next;
  logic [N-1:0]   tx_sr_reg, rx_sr_reg, buf_reg, rx_data_reg;
  logic           buf_full_reg, rx_valid_reg;
  logic [CW-1:0]  bit_cnt_reg;

  logic           in_shift, do_rise, do_fall, word_done, consume, write;
  logic [N-1:0]   load_word, rx_word;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_fall) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = SHIFT;
      default: state_next = IDLE;
    endcase
    // Deselect always wins, including over a word completing this cycle.
    if (ss_rise) state_next = IDLE;
  end

  assign in_shift  = (state_reg == SHIFT) && !ss_rise;
  assign do_rise   = in_shift && sclk_rise;
  assign do_fall   = in_shift && sclk_fall;
  assign word_done = do_rise && (bit_cnt_reg == CW'(N-1));
  assign consume   = ((state_reg == LOAD) && !ss_rise) || (do_fall && (bit_cnt_reg == '0));
  assign write     = tx_valid && !buf_full_reg;
  assign load_word = buf_full_reg ? buf_reg : '0;
  assign rx_word   = {rx_sr_reg[N-2:0], mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      bit_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rx_valid_reg <= word_done;
      if (write) buf_reg <= tx_data;
      // A consume in the same cycle as a write sees the old (empty) buffer.
      buf_full_reg <= write || (buf_full_reg && !consume);
      if (consume)      tx_sr_reg <= load_word;
      else if (do_fall) tx_sr_reg <= {tx_sr_reg[N-2:0], 1'b0};
      if (state_reg == LOAD) bit_cnt_reg <= '0;
      if (do_rise) begin
        rx_sr_reg   <= rx_word;
        bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
      end
      if (word_done) rx_data_reg <= rx_word;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       underrun_reg <= 1'b0;
    else if (consume && !buf_full_reg) underrun_reg <= 1'b1;
    else if (underrun_clr)           underrun_reg <= 1'b0;
  end
  assign underrun = underrun_reg;
`endif

  assign busy     = (state_reg != IDLE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_sr_reg[N-1];
  assign tx_ready = !buf_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master plus a queue model
// of the one-word tx buffer. Define SPI_SLAVE_UNDERRUN_EN to cover the flag.
module tb_spi_slave;
  localparam int N = 8;

  logic         clk = 1'b0, reset = 1'b1;
  logic         sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [N-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         miso, miso_oe, tx_ready, rx_valid, busy;
  logic [N-1:0] rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun, underrun_clr = 1'b0;
`endif

  spi_slave #(.N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .underrun(underrun), .underrun_clr(underrun_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  logic [N-1:0] rx_q[$];        // every word seen with an rx_valid strobe
  logic [N-1:0] tx_model[$];    // words written into the tx buffer, not yet consumed
  logic [N-1:0] mosi_words[$];
  logic [N-1:0] miso_got[$];
  logic [N-1:0] exp_rx[$];
  logic [N-1:0] last_rx;

  always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each buffer consumption (frame start or word boundary) takes the oldest word or zeros.
  function automatic logic [N-1:0] take();
    if (tx_model.size() > 0) return tx_model.pop_front();
    return '0;
  endfunction

  task automatic write_buf(input logic [N-1:0] w);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_data = w; tx_valid = 1'b1; done = 1;
      end
    end
    if (!done) check("write_timeout", 0, 1);
    else begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_model.push_back(w);
      check("tx_ready_after_write", tx_ready, 0);
    end
  endtask

  task automatic xfer(input logic [N-1:0] w, input int half, output logic [N-1:0] g);
    for (int i = N - 1; i >= 0; i--) begin
      mosi = w[i];
      wait_clk(half);
      g[i] = miso;
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int half);
    logic [N-1:0] g;
    ss_n = 1'b0;
    wait_clk(8);
    check("busy_in_frame", busy, 1);
    check("miso_oe_in_frame", miso_oe, 1);
    foreach (mosi_words[k]) begin
      xfer(mosi_words[k], half, g);
      miso_got.push_back(g);
    end
    wait_clk(6);
    ss_n = 1'b1;
    wait_clk(8);
    check("busy_after_frame", busy, 0);
    $display("frame: %0d word(s), sclk half=%0d clk", mosi_words.size(), half);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] e1, e2, g;
    int left, nw;

    wait_clk(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_clk(3);

    // Single word: A5 out, 3C in.
    write_buf(8'hA5);
    rx_q.delete(); miso_got.delete(); mosi_words = '{8'h3C};
    e1 = take();
    frame(8);
    void'(take());
    check("t2_miso_word", miso_got[0], e1);
    check("t2_rx_count", rx_q.size(), 1);
    check("t2_rx_word", rx_q.size() > 0 ? rx_q[0] : 'x, 8'h3C);
    check("t2_rx_data", rx_data, 8'h3C);

    // Reset after three bits of a frame.
    rx_q.delete();
    ss_n = 1'b0;
    wait_clk(8);
    write_buf(8'h5A);
    for (int i = 0; i < 3; i++) begin
      mosi = i[0]; wait_clk(8); sclk = 1'b1; wait_clk(8); sclk = 1'b0;
    end
    reset = 1'b1;
    wait_clk(2);
    check_reset_values("t1_in_reset");
    reset = 1'b0;
    tx_model.delete();
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; wait_clk(8); sclk = 1'b1; wait_clk(8); sclk = 1'b0;
    end
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(8);
    check_reset_values("t1_after");
    check("t1_rx_count", rx_q.size(), 0);

    // Two-word frame; second tx word written while word 1 is shifting.
    rx_q.delete(); miso_got.delete();
    mosi_words = '{N'($urandom), N'($urandom)};
    write_buf(8'h81);
    e1 = take();
    fork
      frame(8);
      begin wait_clk(40); write_buf(8'h7E); end
    join
    e2 = take();
    void'(take());
    check("t3_miso_w1", miso_got[0], e1);
    check("t3_miso_w2", miso_got[1], e2);
    check("t3_rx_count", rx_q.size(), 2);
    check("t3_rx_w1", rx_q.size() > 0 ? rx_q[0] : 'x, mosi_words[0]);
    check("t3_rx_w2", rx_q.size() > 1 ? rx_q[1] : 'x, mosi_words[1]);
    last_rx = mosi_words[1];

    // Abort after five sclk edges.
    rx_q.delete();
    ss_n = 1'b0;
    wait_clk(8);
    void'(take());
    for (int e = 0; e < 5; e++) begin
      mosi = 1'(e); sclk = ~sclk; wait_clk(8);
    end
    ss_n = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(8);
    check("t4_rx_count", rx_q.size(), 0);
    check("t4_rx_data_held", rx_data, last_rx);
    check("t4_busy", busy, 0);
    check("t4_miso_oe", miso_oe, 0);

    // Empty buffer at frame start.
    check("t5_tx_ready", tx_ready, tx_model.size() == 0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_clr = 1'b1; wait_clk(1); underrun_clr = 1'b0; wait_clk(1);
    check("t5_underrun_cleared_pre", underrun, 0);
`endif
    rx_q.delete(); miso_got.delete();
    mosi_words = '{N'($urandom)};
    e1 = take();
    frame(8);
    void'(take());
    check("t5_miso_zero", miso_got[0], e1);
    check("t5_rx_word", rx_q.size() > 0 ? rx_q[0] : 'x, mosi_words[0]);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("t5_underrun_set", underrun, 1);
    underrun_clr = 1'b1; wait_clk(1); underrun_clr = 1'b0; wait_clk(1);
    check("t5_underrun_clr", underrun, 0);
`endif

    // 100 random words at sclk = clk/4 in frames of 1..4 words.
    rx_q.delete(); exp_rx.delete();
    left = 100;
    while (left > 0) begin
      nw = $urandom_range(1, 4);
      if (nw > left) nw = left;
      mosi_words.delete(); miso_got.delete();
      for (int k = 0; k < nw; k++) begin
        g = N'($urandom);
        mosi_words.push_back(g);
        exp_rx.push_back(g);
      end
      frame(2);
      left -= nw;
    end
    check("t6_rx_count", rx_q.size(), exp_rx.size());
    foreach (exp_rx[k])
      check($sformatf("t6_rx_w%0d", k), k < rx_q.size() ? rx_q[k] : 'x, exp_rx[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
